cache_mem_responder: RTL and testbench

//  Memory-side responder for the direct-mapped cache bus: accepts one line

---
 rtl/cache_mem_responder_if.sv | 32 +++
 rtl/cache_mem_responder.sv | 156 +++++++++++++++
 tb/tb_cache_mem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_responder_if.sv
// Request/response bus between the direct-mapped cache (master) and the
// memory-side responder (slave).
//
// Handshake: a request is taken on the rising edge where req_valid=1 and
// busy=0. While busy=1, req_valid is ignored and nothing is queued, so the
// master must keep the request asserted until it observes busy go high.
// Every accepted request completes with exactly one resp_valid cycle, and
// resp_data is meaningful only in that cycle and only for reads.
interface cache_mem_responder_if #(
    parameter int addr_width = 8,
    parameter int data_width = 8
);
    logic                  req_valid;
    logic                  req_rw;
    logic [addr_width-1:0] req_addr;
    logic [data_width-1:0] req_wdata;
    logic                  busy;
    logic                  resp_valid;
    logic [data_width-1:0] resp_data;
    logic [15:0]           rd_count;
    logic [15:0]           wr_count;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  busy, resp_valid, resp_data, rd_count, wr_count
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output busy, resp_valid, resp_data, rd_count, wr_count
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the direct-mapped cache bus.
// Accepts one read (refill) or write at a time, stays busy for LATENCY
// cycles, then pulses resp_valid for one cycle (with data for reads).
// Storage is a 2**addr_width word array that is not reset.
//
// Optional feature macro: MEM_STATS_EN
//   defined   -> rd_count/wr_count count completed reads/writes and
//                saturate at 16'hFFFF
//   undefined -> rd_count/wr_count are tied to zero
//
// state_dbg exposes the FSM state (0 = IDLE, 1 = ACCESS).
module cache_mem_responder #(
    parameter int addr_width = 8,
    parameter int data_width = 8,
    parameter int LATENCY    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    cache_mem_responder_if.slave        bus,
    output logic                        state_dbg
);

    // A down-counter from LATENCY-1 to 0 needs at least one bit.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << addr_width;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      cnt;
    logic                  accept;
    logic                  finish;

    logic                  lat_rw;
    logic [addr_width-1:0] lat_addr;
    logic [data_width-1:0] lat_wdata;

    logic                  resp_valid_q;
    logic [data_width-1:0] resp_data_q;

    logic [data_width-1:0] mem [0:DEPTH-1];

    // Reject a zero or negative latency at elaboration time.
    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("cache_mem_responder: LATENCY must be >= 1");
        end
    endgenerate

    // State register; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE waits for a request, ACCESS waits for cnt==0.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.req_valid) next_state = ACCESS;
            ACCESS:  if (cnt == '0)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: accept strobe in IDLE, completion strobe in ACCESS.
    always_comb begin
        accept = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE:    accept = bus.req_valid;
            ACCESS:  finish = (cnt == '0);
            default: begin
                accept = 1'b0;
                finish = 1'b0;
            end
        endcase
    end

    // Request latch and latency counter; req_* is sampled only on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            cnt       <= CNT_W'(LATENCY - 1);
            lat_rw    <= bus.req_rw;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Response registers: one-cycle pulse; data updates on reads only.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= finish;
            if (finish && lat_rw) begin
                resp_data_q <= mem[lat_addr];
            end
        end
    end

    // Array write at completion; a reset in the same cycle drops the write.
    always_ff @(posedge clk) begin
        if (!reset && finish && !lat_rw) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    // Completion counters, bumped alongside resp_valid and held at 16'hFFFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (finish) begin
            if (lat_rw && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (!lat_rw && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign bus.rd_count = rd_cnt_q;
    assign bus.wr_count = wr_cnt_q;
`else
    assign bus.rd_count = 16'h0000;
    assign bus.wr_count = 16'h0000;
`endif

    // busy is the ACCESS state itself, which is already a register.
    assign bus.busy       = (state == ACCESS);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a LATENCY=4 instance driven from a
// vector table plus hand sequences (held request, reset mid-write,
// counter saturation), and a LATENCY=1 instance streamed with
// alternating write/read over every address.
module tb_cache_mem_responder;

    localparam int L4 = 4;

    logic clk = 1'b0;
    logic reset;
    logic dbg4;
    logic dbg1;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_rd4 = 16'h0;
    logic [15:0] exp_wr4 = 16'h0;

    cache_mem_responder_if #(.addr_width(8), .data_width(8)) bus4 ();
    cache_mem_responder_if #(.addr_width(8), .data_width(8)) bus1 ();

    cache_mem_responder #(.addr_width(8), .data_width(8), .LATENCY(L4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus4.slave),
        .state_dbg (dbg4)
    );

    cache_mem_responder #(.addr_width(8), .data_width(8), .LATENCY(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1.slave),
        .state_dbg (dbg1)
    );

    // Clock: 10 ns period, DUT acts on rising edge.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    logic [7:0] model_mem [256];
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counter value expected on the ports for a given model count.
    function automatic logic [15:0] stat(input logic [15:0] m);
`ifdef MEM_STATS_EN
        return m;
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Wait (bounded) for dut4 to take the request; returns at edge+1ns.
    task automatic wait_accept4(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (bus4.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at accept edge+1ns: checks latency, busy span, pulse and data.
    task automatic wait_resp4(input logic rw, input logic [7:0] exp_data);
        int  lat      = 0;
        int  busy_cnt = 0;
        bit  got      = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus4.resp_valid) begin
                got = 1'b1;
                break;
            end
            if (bus4.busy) busy_cnt++;
        end
        check("resp_seen", 32'(got), 32'd1);
        check("resp_latency", 32'(lat), 32'(L4));
        check("busy_span", 32'(busy_cnt + 1), 32'(L4));
        check("busy_at_resp", 32'(bus4.busy), 32'd0);
        check("resp_data", 32'(bus4.resp_data), 32'(exp_data));
        if (rw) exp_rd4 = sat_inc(exp_rd4);
        else    exp_wr4 = sat_inc(exp_wr4);
        check("rd_count", 32'(bus4.rd_count), 32'(stat(exp_rd4)));
        check("wr_count", 32'(bus4.wr_count), 32'(stat(exp_wr4)));
        @(posedge clk);
        #1;
        check("resp_pulse_width", 32'(bus4.resp_valid), 32'd0);
    endtask

    // Driver: one complete request on dut4.
    task automatic req4(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_data);
        bit ok;
        @(negedge clk);
        bus4.req_valid = 1'b1;
        bus4.req_rw    = rw;
        bus4.req_addr  = addr;
        bus4.req_wdata = wdata;
        wait_accept4(ok);
        check("accept", 32'(ok), 32'd1);
        bus4.req_valid = 1'b0;
        bus4.req_addr  = 8'hEE;
        bus4.req_wdata = 8'hEE;
        wait_resp4(rw, exp_data);
    endtask

    // Stream operation k on dut1: even = write, odd = read, addr = k/2.
    task automatic set_op1(input int k);
        logic [7:0] a;
        a = 8'(k >> 1);
        bus1.req_rw    = k[0];
        bus1.req_addr  = a;
        bus1.req_wdata = (a * 8'd7 + 8'd3) ^ 8'hA5;
    endtask

    initial begin
        bit         ok;
        int         e;
        int         seen;
        int         k;
        int         nresp;
        int         cycles;
        logic       prev_busy;
        logic [7:0] last_rd;
        logic [7:0] exp_d;

        // Vector table: reads expect stored data, writes expect held resp_data.
        vecs[0] = '{rw: 1'b0, addr: 8'h35, wdata: 8'hA7, exp_data: 8'h00};
        vecs[1] = '{rw: 1'b1, addr: 8'h35, wdata: 8'h00, exp_data: 8'hA7};
        vecs[2] = '{rw: 1'b0, addr: 8'h02, wdata: 8'h33, exp_data: 8'hA7};
        vecs[3] = '{rw: 1'b1, addr: 8'h02, wdata: 8'h99, exp_data: 8'h33};
        vecs[4] = '{rw: 1'b0, addr: 8'h80, wdata: 8'hC3, exp_data: 8'h33};
        vecs[5] = '{rw: 1'b1, addr: 8'h80, wdata: 8'h00, exp_data: 8'hC3};
        vecs[6] = '{rw: 1'b1, addr: 8'h35, wdata: 8'h00, exp_data: 8'hA7};

        // Clock/reset block.
        reset          = 1'b1;
        bus4.req_valid = 1'b0;
        bus4.req_rw    = 1'b0;
        bus4.req_addr  = 8'h00;
        bus4.req_wdata = 8'h00;
        bus1.req_valid = 1'b0;
        bus1.req_rw    = 1'b0;
        bus1.req_addr  = 8'h00;
        bus1.req_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_resp_valid", 32'(bus4.resp_valid), 32'd0);
        check("rst_resp_data", 32'(bus4.resp_data), 32'd0);
        check("rst_rd_count", 32'(bus4.rd_count), 32'd0);
        check("rst_wr_count", 32'(bus4.wr_count), 32'd0);
        check("rst_state", 32'(dbg4), 32'd0);
        check("rst_busy_l1", 32'(bus1.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven transactions (write/read 8'h35 etc.).
        for (int i = 0; i < 7; i++) begin
            req4(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data);
        end

        // Read of 8'h10 held during a write of 8'h5C to 8'h10.
        @(negedge clk);
        bus4.req_valid = 1'b1;
        bus4.req_rw    = 1'b0;
        bus4.req_addr  = 8'h10;
        bus4.req_wdata = 8'h5C;
        wait_accept4(ok);
        check("hold_accept_wr", 32'(ok), 32'd1);
        bus4.req_rw    = 1'b1;
        bus4.req_wdata = 8'h00;
        e = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            e++;
            if (bus4.resp_valid) break;
        end
        check("hold_wr_latency", 32'(e), 32'(L4));
        check("hold_wr_busy_low", 32'(bus4.busy), 32'd0);
        check("hold_wr_data_held", 32'(bus4.resp_data), 32'hA7);
        exp_wr4 = sat_inc(exp_wr4);
        check("hold_wr_count", 32'(bus4.wr_count), 32'(stat(exp_wr4)));
        @(posedge clk);
        #1;
        check("hold_rd_accepted", 32'(bus4.busy), 32'd1);
        check("hold_resp_pulse", 32'(bus4.resp_valid), 32'd0);
        bus4.req_valid = 1'b0;
        wait_resp4(1'b1, 8'h5C);

        // Reset two cycles into a write of 8'hFF to 8'h02.
        @(negedge clk);
        bus4.req_valid = 1'b1;
        bus4.req_rw    = 1'b0;
        bus4.req_addr  = 8'h02;
        bus4.req_wdata = 8'hFF;
        wait_accept4(ok);
        check("abort_accept", 32'(ok), 32'd1);
        bus4.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_rd4 = 16'h0;
        exp_wr4 = 16'h0;
        check("abort_busy", 32'(bus4.busy), 32'd0);
        check("abort_resp_valid", 32'(bus4.resp_valid), 32'd0);
        check("abort_resp_data", 32'(bus4.resp_data), 32'd0);
        check("abort_rd_count", 32'(bus4.rd_count), 32'd0);
        check("abort_wr_count", 32'(bus4.wr_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus4.resp_valid) seen++;
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        req4(1'b1, 8'h02, 8'h00, 8'h33);
        req4(1'b0, 8'h02, 8'h11, 8'h33);
        req4(1'b1, 8'h02, 8'h00, 8'h11);

        // Counter saturation: preload read counter near the limit.
`ifdef MEM_STATS_EN
        @(negedge clk);
        force dut4.rd_cnt_q = 16'hFFFE;
        #1;
        release dut4.rd_cnt_q;
        exp_rd4 = 16'hFFFE;
`endif
        for (int i = 0; i < 3; i++) begin
            req4(1'b1, 8'h80, 8'h00, 8'hC3);
        end

        // LATENCY=1 stream: write/read alternating over all addresses.
        last_rd = 8'h00;
        k       = 0;
        nresp   = 0;
        cycles  = 0;
        prev_busy = 1'b0;
        @(negedge clk);
        set_op1(0);
        bus1.req_valid = 1'b1;
        while (nresp < 512 && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (k > 0 && nresp < 511) begin
                check("l1_alternate", 32'(bus1.busy ^ bus1.resp_valid), 32'd1);
            end
            if (bus1.resp_valid) begin
                check("l1_busy_before_resp", 32'(prev_busy), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    check("l1_resp_data", 32'(bus1.resp_data), 32'(exp_d));
                end else begin
                    check("l1_unexpected_resp", 32'd1, 32'd0);
                end
                nresp++;
            end
            if (bus1.busy && k < 512) begin
                if (bus1.req_rw) begin
                    last_rd = model_mem[bus1.req_addr];
                end else begin
                    model_mem[bus1.req_addr] = bus1.req_wdata;
                end
                exp_q.push_back(last_rd);
                k++;
                if (k < 512) set_op1(k);
                else bus1.req_valid = 1'b0;
            end
            prev_busy = bus1.busy;
        end
        check("l1_all_responses", 32'(nresp), 32'd512);
        check("l1_cycles", 32'(cycles), 32'd1024);
        check("l1_rd_count", 32'(bus1.rd_count), 32'(stat(16'd256)));
        check("l1_wr_count", 32'(bus1.wr_count), 32'(stat(16'd256)));

        // Final report.
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
